alarm_arbiter: RTL and testbench
================================

# alarm_arbiter

Shares the single alarm output channel (siren plus display code) between the four event sources raised by the security control FSM: fire, panic, intrusion and password lockout. Requests are latched as pending and granted by fixed priority. Each grant is held for a minimum on-time and released only by a user acknowledge. A higher-priority event preempts a lower one. A cooldown separates consecutive alarms. The block sits between the control FSM's event outputs and the siren and display drivers.

## Interface
- `HOLD_CYCLES`, default 16: minimum cycles an alarm is held before `ack` is honoured; 1 ≤ value ≤ 2^`CW`.
- `COOLDOWN_CYCLES`, default 4: cycles with the channel idle after an acknowledged alarm; 1 ≤ value ≤ 2^`CW`.
- `CW`, default 8: width of the shared hold/cooldown counter.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req`  in  4  level requests; bit 0 fire, bit 1 panic, bit 2 intrusion, bit 3 lockout; lower index has higher priority.
- `ack`  in  1  user acknowledge, sampled each cycle.
- `grant`  out  4  one-hot; the source currently owning the channel, or 0.
- `siren`  out  1  high while in ALARM.
- `code`  out  2  index of the granted source; 0 when no source is granted.
- `busy`  out  1  high in ALARM or COOLDOWN.
- `pending`  out  4  latched requests not yet acknowledged.

## Operation
- Pending register:
  - `pending[i]` sets on any edge where `req[i]`=1.
  - It clears only when source i is acknowledged.
  - If set and clear hit the same bit on the same edge, set wins.
- States: IDLE, ALARM, COOLDOWN. Encodings are 2'b00, 2'b01, 2'b10; 2'b11 is illegal and recovers to IDLE.
- IDLE:
  - `pending`=0 → stay in IDLE.
  - Otherwise → ALARM, with `grant` set to the highest-priority pending bit and `cnt` loaded with `HOLD_CYCLES`-1.
- ALARM, preemption:
  - Checked every cycle, ahead of all other ALARM rules.
  - If a pending bit of strictly higher priority than the current grant is set, switch `grant` to it on the next edge and reload `cnt` with `HOLD_CYCLES`-1.
  - The preempted source stays pending.
- ALARM, hold:
  - While `cnt`≠0, decrement `cnt` and ignore `ack`.
  - While `cnt`=0 and `ack`=0, hold in ALARM.
- ALARM, release:
  - When `cnt`=0 and `ack`=1, clear `pending[granted]`, clear `grant`, load `cnt` with `COOLDOWN_CYCLES`-1, and go to COOLDOWN.
  - If preemption and release coincide, preemption wins and `ack` is ignored.
- COOLDOWN:
  - `grant`=0 and `siren`=0.
  - While `cnt`≠0, decrement.
  - When `cnt`=0, go to IDLE.
  - New requests still latch into `pending`.
- Reset, whether mid-ALARM or otherwise, returns to IDLE. Pending requests are discarded; a source must re-assert `req`.

## Timing
- Reset values: state IDLE, `cnt`=0, `pending`=0, `grant`=0, `siren`=0, `code`=0, `busy`=0.
- All outputs are registered or decoded from registered state only; no combinational path from input to output.
- Request latency:
  - `req` high at edge k → `pending` set after k.
  - From IDLE, `grant`, `siren` and `busy` are high after edge k+1.
- Hold: `grant` is high for at least `HOLD_CYCLES` cycles. The earliest honoured `ack` is in ALARM cycle `HOLD_CYCLES`, counting the entry cycle as cycle 1.
- Release: `grant` drops on the edge that samples the honoured `ack`.
- Cooldown gap: `COOLDOWN_CYCLES` cycles in COOLDOWN plus 1 cycle in IDLE before the next grant, i.e. `COOLDOWN_CYCLES`+1 cycles with `grant`=0.
- Preemption latency: a higher-priority `req` at edge k → `grant` switches after edge k+1.
- `cnt` never wraps. It is only loaded or decremented from a nonzero value.

## Structure
- Package `alarm_pkg` holds:
  - state encodings;
  - source index constants `SRC_FIRE`=0, `SRC_PANIC`=1, `SRC_INTRUSION`=2, `SRC_LOCKOUT`=3;
  - code width 2 and request width 4.
- One sub-module, `alarm_prio_enc`: combinational 4-bit fixed-priority encoder producing a one-hot output and a 2-bit index, plus a "strictly higher than current grant" compare. It is used both for IDLE selection and for the preemption check.
- FSM, counter and pending register live in `alarm_arbiter`.

## Test plan
All scenarios use `HOLD_CYCLES`=4 and `COOLDOWN_CYCLES`=2.
- Single request: `req`=4'b0100 pulsed 1 cycle → `pending`=4'b0100 next cycle; `grant`=4'b0100, `code`=2, `siren`=1 a cycle later; `ack` held high throughout → `grant` drops after exactly 4 ALARM cycles; `pending`=0; `busy` is low 2 cycles later.
- Early ack ignored: `ack` pulsed in ALARM cycle 2 only → grant persists indefinitely; a later `ack` releases it.
- Priority from IDLE: `req`=4'b1010 together → `grant`=4'b0010 first; after ack and 3 idle cycles (2 COOLDOWN + 1 IDLE), `grant`=4'b1000, `code`=3.
- Preemption: lockout in ALARM cycle 3, fire `req` asserted → grant switches to 4'b0001 after 2 edges; hold restarts at 4 cycles; `pending`=4'b1001; after both acks, `pending`=0.
- Re-arm race: `req[2]` high on the same edge as the honoured `ack` for source 2 → `pending[2]` stays 1; source 2 is re-granted after cooldown.
- Async reset: assert `reset` mid-ALARM between clock edges → all outputs 0 immediately, state IDLE; no grant after release until a new `req`.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm channel arbiter.
// Sources are indexed by priority: a lower index wins.
package alarm_pkg;

    localparam int REQ_W  = 4;
    localparam int CODE_W = 2;

    localparam int SRC_FIRE      = 0;
    localparam int SRC_PANIC     = 1;
    localparam int SRC_INTRUSION = 2;
    localparam int SRC_LOCKOUT   = 3;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ALARM    = 2'b01,
        ST_COOLDOWN = 2'b10
    } state_e;

endpackage

// File: rtl/alarm_prio_enc.sv
// Fixed-priority encoder over the pending sources, plus a check for a
// pending source that strictly outranks the current grant.
module alarm_prio_enc
    import alarm_pkg::*;
(
    input  logic [REQ_W-1:0]  req,
    input  logic [REQ_W-1:0]  cur,
    output logic [REQ_W-1:0]  onehot,
    output logic [CODE_W-1:0] idx,
    output logic              any,
    output logic              higher
);

    localparam logic [REQ_W-1:0] ONE = {{(REQ_W-1){1'b0}}, 1'b1};

    logic [REQ_W-1:0] above_mask;

    always_comb begin
        onehot = '0;
        idx    = '0;
        for (int i = REQ_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = CODE_W'(i);
            end
        end
    end

    // cur is one-hot or zero; cur-1 marks every index that outranks it,
    // and with no grant it marks all sources.
    assign above_mask = cur - ONE;
    assign any        = |req;
    assign higher     = |(req & above_mask);

endmodule

// File: rtl/alarm_arbiter.sv
// Arbitrates the single siren/display channel between the four alarm sources,
// with a minimum on-time, user acknowledge, preemption and a cooldown gap.
//
// state       | meaning
// ------------+---------------------------------------------------------
// ST_IDLE     | channel free; grants the top pending source next edge
// ST_ALARM    | source owns the channel; cnt counts down the hold time
// ST_COOLDOWN | channel forced idle after an ack; cnt counts the gap
// 2'b11       | illegal; falls back to ST_IDLE
module alarm_arbiter
    import alarm_pkg::*;
#(
    parameter int HOLD_CYCLES     = 16,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int CW              = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REQ_W-1:0]  req,
    input  logic              ack,
    output logic [REQ_W-1:0]  grant,
    output logic              siren,
    output logic [CODE_W-1:0] code,
    output logic              busy,
    output logic [REQ_W-1:0]  pending
);

    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] COOL_LOAD = CW'(COOLDOWN_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    logic [1:0]        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [REQ_W-1:0]  grant_q, grant_d;
    logic [CODE_W-1:0] code_q, code_d;
    logic [REQ_W-1:0]  pending_q;
    logic [REQ_W-1:0]  clr_mask;
    logic              release_hit;

    logic [REQ_W-1:0]  enc_onehot;
    logic [CODE_W-1:0] enc_idx;
    logic              enc_any;
    logic              enc_higher;

    alarm_prio_enc u_prio_enc (
        .req    (pending_q),
        .cur    (grant_q),
        .onehot (enc_onehot),
        .idx    (enc_idx),
        .any    (enc_any),
        .higher (enc_higher)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            grant_q <= '0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        code_d      = code_q;
        release_hit = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (enc_any) begin
                    state_d = ST_ALARM;
                    grant_d = enc_onehot;
                    code_d  = enc_idx;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_ALARM: begin
                // Preemption outranks both the hold countdown and the ack.
                if (enc_higher) begin
                    grant_d = enc_onehot;
                    code_d  = enc_idx;
                    cnt_d   = HOLD_LOAD;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else if (ack) begin
                    release_hit = 1'b1;
                    grant_d     = '0;
                    code_d      = '0;
                    cnt_d       = COOL_LOAD;
                    state_d     = ST_COOLDOWN;
                end
            end
            ST_COOLDOWN: begin
                grant_d = '0;
                code_d  = '0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_ONE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                grant_d = '0;
                code_d  = '0;
            end
        endcase
    end

    // A request landing on the same edge as its own ack re-arms the source.
    assign clr_mask = release_hit ? grant_q : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | req;
        end
    end

    always_comb begin
        grant   = grant_q;
        code    = code_q;
        pending = pending_q;
        siren   = (state_q == ST_ALARM);
        busy    = (state_q == ST_ALARM) || (state_q == ST_COOLDOWN);
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_q));

    a_grant_only_in_alarm: assert property (@(posedge clk) disable iff (reset)
        (grant_q != '0) == (state_q == ST_ALARM));

    a_cooldown_exit: assert property (@(posedge clk) disable iff (reset)
        (state_q == ST_COOLDOWN && cnt_q == '0) |=> (state_q == ST_IDLE));

endmodule

// File: tb/tb_alarm_arbiter.sv
// Scoreboard bench for alarm_arbiter: a timestamp-based reference model predicts
// the outputs after every edge, and an independent monitor compares them.
module tb_alarm_arbiter;

    localparam int HOLD = 4;
    localparam int COOL = 2;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       ack;
    logic [3:0] grant;
    logic       siren;
    logic [1:0] code;
    logic       busy;
    logic [3:0] pending;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] grant;
        logic [1:0] code;
        logic       siren;
        logic       busy;
        logic [3:0] pending;
    } exp_t;

    exp_t exp_q[$];

    alarm_arbiter #(
        .HOLD_CYCLES     (HOLD),
        .COOLDOWN_CYCLES (COOL),
        .CW              (8)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .ack     (ack),
        .grant   (grant),
        .siren   (siren),
        .code    (code),
        .busy    (busy),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Reference model: tracks the owner, the edge it was granted on and the
    // edge of the last release, and derives timing from those timestamps.
    int         cyc     = 0;
    int         owner   = -1;
    int         ent     = 0;
    int         rel     = -100;
    logic [3:0] pend_m  = '0;

    always begin
        exp_t e;
        int   hi;
        @(posedge clk);
        cyc++;
        if (reset) begin
            owner  = -1;
            rel    = -100;
            pend_m = '0;
        end else begin
            hi = -1;
            for (int b = 3; b >= 0; b--) if (pend_m[b]) hi = b;
            if (owner >= 0) begin
                if (hi >= 0 && hi < owner) begin
                    owner = hi;
                    ent   = cyc;
                end else if ((cyc - ent) >= HOLD && ack) begin
                    pend_m[owner] = 1'b0;
                    owner         = -1;
                    rel           = cyc;
                end
            end else if (cyc >= rel + COOL + 1 && hi >= 0) begin
                owner = hi;
                ent   = cyc;
            end
            pend_m = pend_m | req;
        end
        e.grant   = (owner >= 0) ? 4'(1 << owner) : 4'b0;
        e.code    = (owner >= 0) ? 2'(owner) : 2'b0;
        e.siren   = (owner >= 0);
        e.busy    = (owner >= 0) || (cyc < rel + COOL);
        e.pending = pend_m;
        exp_q.push_back(e);
    end

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty queue expected an entry at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("grant",   32'(grant),   32'(e.grant));
            chk("code",    32'(code),    32'(e.code));
            chk("siren",   32'(siren),   32'(e.siren));
            chk("busy",    32'(busy),    32'(e.busy));
            chk("pending", 32'(pending), 32'(e.pending));
        end
    end

    task automatic step(input logic [3:0] r, input logic a);
        @(negedge clk);
        req = r;
        ack = a;
    endtask

    task automatic idle(input int n, input logic a);
        repeat (n) step(4'b0000, a);
    endtask

    // Reset raised between edges must clear the outputs without a clock.
    task automatic async_reset();
        @(negedge clk);
        req = 4'b0000;
        ack = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rst_grant",   32'(grant),   32'h0);
        chk("rst_siren",   32'(siren),   32'h0);
        chk("rst_code",    32'(code),    32'h0);
        chk("rst_busy",    32'(busy),    32'h0);
        chk("rst_pending", 32'(pending), 32'h0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL timeout: got no finish expected finish within bound");
        $fatal(1, "bench timeout");
    end

    initial begin
        logic [3:0] r;
        reset = 1'b1;
        req   = 4'b0000;
        ack   = 1'b0;
        #1;
        chk("init_grant", 32'(grant), 32'h0);
        chk("init_busy",  32'(busy),  32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        idle(2, 1'b0);

        // single request with ack held high throughout
        step(4'b0100, 1'b1);
        idle(10, 1'b1);
        idle(3, 1'b0);

        // early ack ignored, later ack releases
        step(4'b0001, 1'b0);
        idle(2, 1'b0);
        step(4'b0000, 1'b1);
        idle(8, 1'b0);
        step(4'b0000, 1'b1);
        idle(4, 1'b0);

        // simultaneous requests resolved by priority
        step(4'b1010, 1'b0);
        idle(5, 1'b0);
        idle(20, 1'b1);
        idle(3, 1'b0);

        // fire preempts lockout
        step(4'b1000, 1'b0);
        idle(3, 1'b0);
        step(4'b0001, 1'b0);
        idle(6, 1'b0);
        idle(20, 1'b1);
        idle(3, 1'b0);

        // request and honoured ack for the same source on the same edge
        step(4'b0100, 1'b0);
        idle(6, 1'b0);
        repeat (3) step(4'b0100, 1'b1);
        idle(12, 1'b1);
        idle(4, 1'b0);

        // async reset in the middle of an alarm
        step(4'b0010, 1'b0);
        idle(3, 1'b0);
        async_reset();
        idle(10, 1'b0);

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                async_reset();
            end else begin
                r = 4'b0000;
                for (int b = 0; b < 4; b++) if ($urandom_range(0, 11) == 0) r[b] = 1'b1;
                step(r, ($urandom_range(0, 2) == 0));
            end
        end
        idle(20, 1'b1);

        @(posedge clk);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
